// File: rtl/fwd_hazard_ctrl.sv
// EX-stage forwarding-select and load-use stall control. Tracks shadow copies of the
// destination/RegWrite/MemRead fields for the ID/EX, EX/MEM and MEM/WB stages.
module fwd_hazard_ctrl #(
   parameter int REG_W = 5,
   parameter int SEL_W = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             hold_i,
   input  logic             flush_i,
   input  logic [REG_W-1:0] id_rs_i,
   input  logic [REG_W-1:0] id_rt_i,
   input  logic [REG_W-1:0] id_rd_i,
   input  logic             id_regwrite_i,
   input  logic             id_memread_i,
   output logic [SEL_W-1:0] fwd_a_o,
   output logic [SEL_W-1:0] fwd_b_o,
   output logic             stall_o,
   output logic             pc_write_o,
   output logic             ifid_write_o
);

   localparam logic [SEL_W-1:0] SEL_RF    = 2'b00;
   localparam logic [SEL_W-1:0] SEL_MEMWB = 2'b01;
   localparam logic [SEL_W-1:0] SEL_EXMEM = 2'b10;
   localparam logic [REG_W-1:0] REG_ZERO  = {REG_W{1'b0}};

   logic [REG_W-1:0] r_ex_rs, r_ex_rt, r_ex_rd, r_mem_rd, r_wb_rd;
   logic             r_ex_rw, r_ex_mr, r_mem_rw, r_wb_rw;
   logic             w_load_hit, w_stall, w_bubble;

   // The most recent producer (EX/MEM) wins; register 0 is never a forwarding source.
   function automatic logic [SEL_W-1:0] fwd_sel(
      input logic [REG_W-1:0] src,
      input logic             mem_rw,
      input logic [REG_W-1:0] mem_rd,
      input logic             wb_rw,
      input logic [REG_W-1:0] wb_rd
   );
      logic [SEL_W-1:0] sel;
      if (mem_rw && (mem_rd != REG_ZERO) && (mem_rd == src)) begin
         sel = SEL_EXMEM;
      end else if (wb_rw && (wb_rd != REG_ZERO) && (wb_rd == src)) begin
         sel = SEL_MEMWB;
      end else begin
         sel = SEL_RF;
      end
      return sel;
   endfunction

   // Load-use detection against the instruction still in ID; a flush kills it instead.
   always_comb begin
      w_load_hit = r_ex_mr && (r_ex_rd != REG_ZERO) &&
                   ((r_ex_rd == id_rs_i) || (r_ex_rd == id_rt_i));
      w_stall    = w_load_hit && !flush_i;
      w_bubble   = w_stall || flush_i;
   end

   // Operand selects and pipeline write enables.
   always_comb begin
      fwd_a_o      = fwd_sel(r_ex_rs, r_mem_rw, r_mem_rd, r_wb_rw, r_wb_rd);
      fwd_b_o      = fwd_sel(r_ex_rt, r_mem_rw, r_mem_rd, r_wb_rw, r_wb_rd);
      stall_o      = w_stall;
      pc_write_o   = !w_stall && !hold_i;
      ifid_write_o = !w_stall && !hold_i;
   end

   // Shadow pipeline: reset clears everything and overrides hold; hold freezes all stages.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_ex_rs  <= REG_ZERO;
         r_ex_rt  <= REG_ZERO;
         r_ex_rd  <= REG_ZERO;
         r_ex_rw  <= 1'b0;
         r_ex_mr  <= 1'b0;
         r_mem_rd <= REG_ZERO;
         r_mem_rw <= 1'b0;
         r_wb_rd  <= REG_ZERO;
         r_wb_rw  <= 1'b0;
      end else if (!hold_i) begin
         r_wb_rd  <= r_mem_rd;
         r_wb_rw  <= r_mem_rw;
         r_mem_rd <= r_ex_rd;
         r_mem_rw <= r_ex_rw;
         if (w_bubble) begin
            r_ex_rs <= REG_ZERO;
            r_ex_rt <= REG_ZERO;
            r_ex_rd <= REG_ZERO;
            r_ex_rw <= 1'b0;
            r_ex_mr <= 1'b0;
         end else begin
            r_ex_rs <= id_rs_i;
            r_ex_rt <= id_rt_i;
            r_ex_rd <= id_rd_i;
            r_ex_rw <= id_regwrite_i;
            r_ex_mr <= id_memread_i;
         end
      end else begin
         r_ex_rs  <= r_ex_rs;
         r_ex_rt  <= r_ex_rt;
         r_ex_rd  <= r_ex_rd;
         r_ex_rw  <= r_ex_rw;
         r_ex_mr  <= r_ex_mr;
         r_mem_rd <= r_mem_rd;
         r_mem_rw <= r_mem_rw;
         r_wb_rd  <= r_wb_rd;
         r_wb_rw  <= r_wb_rw;
      end
   end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed, table-driven bench for fwd_hazard_ctrl: each record is one ID-stage cycle
// with the outputs expected before the following rising edge.
module tb_fwd_hazard_ctrl;

   logic       clk_i = 1'b0;
   logic       rst_i, hold_i, flush_i;
   logic [4:0] id_rs_i, id_rt_i, id_rd_i;
   logic       id_regwrite_i, id_memread_i;
   logic [1:0] fwd_a_o, fwd_b_o;
   logic       stall_o, pc_write_o, ifid_write_o;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic       rst, hold, flush;
      logic [4:0] rs, rt, rd;
      logic       rw, mr;
      logic [1:0] ea, eb;
      logic       es, ewr;
   } vec_t;

   vec_t vt[$];

   fwd_hazard_ctrl dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .hold_i        (hold_i),
      .flush_i       (flush_i),
      .id_rs_i       (id_rs_i),
      .id_rt_i       (id_rt_i),
      .id_rd_i       (id_rd_i),
      .id_regwrite_i (id_regwrite_i),
      .id_memread_i  (id_memread_i),
      .fwd_a_o       (fwd_a_o),
      .fwd_b_o       (fwd_b_o),
      .stall_o       (stall_o),
      .pc_write_o    (pc_write_o),
      .ifid_write_o  (ifid_write_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic vec_t mk(input logic rst, input logic hold, input logic flush,
                               input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                               input logic rw, input logic mr,
                               input logic [1:0] ea, input logic [1:0] eb,
                               input logic es, input logic ewr);
      vec_t v;
      v.rst = rst; v.hold = hold; v.flush = flush;
      v.rs = rs; v.rt = rt; v.rd = rd; v.rw = rw; v.mr = mr;
      v.ea = ea; v.eb = eb; v.es = es; v.ewr = ewr;
      return v;
   endfunction

   // Drive one cycle of ID inputs after the falling edge, then check outputs mid-cycle.
   task automatic step(input string name, input vec_t v);
      @(negedge clk_i);
      rst_i = v.rst; hold_i = v.hold; flush_i = v.flush;
      id_rs_i = v.rs; id_rt_i = v.rt; id_rd_i = v.rd;
      id_regwrite_i = v.rw; id_memread_i = v.mr;
      #2;
      n_vec++;
      if (fwd_a_o !== v.ea || fwd_b_o !== v.eb || stall_o !== v.es ||
          pc_write_o !== v.ewr || ifid_write_o !== v.ewr) begin
         n_err++;
         $display("FAIL %s: got a=%b b=%b stall=%b pcw=%b ifw=%b, want a=%b b=%b stall=%b pcw=%b ifw=%b",
                  name, fwd_a_o, fwd_b_o, stall_o, pc_write_o, ifid_write_o,
                  v.ea, v.eb, v.es, v.ewr, v.ewr);
      end
   endtask

   task automatic nop(input string name, input logic hold, input logic [1:0] ea,
                      input logic [1:0] eb, input logic ewr);
      step(name, mk(1'b1, hold, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, ea, eb, 1'b0, ewr));
   endtask

   initial begin
      // reset with busy-looking ID inputs
      vt.push_back(mk(0,0,0, 5,7,5, 1,1, 2'b00,2'b00, 0,1));
      vt.push_back(mk(0,0,0, 5,7,5, 1,1, 2'b00,2'b00, 0,1));
      // EX/MEM forward
      vt.push_back(mk(1,0,0, 1,2,8, 1,0, 2'b00,2'b00, 0,1));
      vt.push_back(mk(1,0,0, 8,9,3, 1,0, 2'b00,2'b00, 0,1));
      vt.push_back(mk(1,0,0, 0,0,0, 0,0, 2'b10,2'b00, 0,1));
      vt.push_back(mk(1,0,0, 0,0,0, 0,0, 2'b00,2'b00, 0,1));
      // MEM/WB forward on A, EX/MEM on B
      vt.push_back(mk(1,0,0, 0,0,8, 1,0, 2'b00,2'b00, 0,1));
      vt.push_back(mk(1,0,0, 0,0,9, 1,0, 2'b00,2'b00, 0,1));
      vt.push_back(mk(1,0,0, 8,9,0, 0,0, 2'b00,2'b00, 0,1));
      vt.push_back(mk(1,0,0, 0,0,0, 0,0, 2'b01,2'b10, 0,1));
      // double producer: EX/MEM priority
      vt.push_back(mk(1,0,0, 0,0,8, 1,0, 2'b00,2'b00, 0,1));
      vt.push_back(mk(1,0,0, 0,0,8, 1,0, 2'b00,2'b00, 0,1));
      vt.push_back(mk(1,0,0, 8,0,0, 0,0, 2'b00,2'b00, 0,1));
      vt.push_back(mk(1,0,0, 0,0,0, 0,0, 2'b10,2'b00, 0,1));
      vt.push_back(mk(1,0,0, 0,0,0, 0,0, 2'b00,2'b00, 0,1));
      // load-use: one stall cycle, then MEM/WB forward on B
      vt.push_back(mk(1,0,0, 0,0,10, 1,1, 2'b00,2'b00, 0,1));
      vt.push_back(mk(1,0,0, 0,10,11, 1,0, 2'b00,2'b00, 1,0));
      vt.push_back(mk(1,0,0, 0,10,11, 1,0, 2'b00,2'b00, 0,1));
      vt.push_back(mk(1,0,0, 0,0,0, 0,0, 2'b00,2'b01, 0,1));
      vt.push_back(mk(1,0,0, 0,0,0, 0,0, 2'b00,2'b00, 0,1));
      vt.push_back(mk(1,0,0, 0,0,0, 0,0, 2'b00,2'b00, 0,1));
      // flush beats stall; flushed instruction never reaches EX
      vt.push_back(mk(1,0,0, 0,0,10, 1,1, 2'b00,2'b00, 0,1));
      vt.push_back(mk(1,0,1, 10,0,12, 1,0, 2'b00,2'b00, 0,1));
      vt.push_back(mk(1,0,0, 0,0,0, 0,0, 2'b00,2'b00, 0,1));
      vt.push_back(mk(1,0,0, 0,0,0, 0,0, 2'b00,2'b00, 0,1));
      // writes to r0 are never forwarded
      vt.push_back(mk(1,0,0, 0,0,0, 1,0, 2'b00,2'b00, 0,1));
      vt.push_back(mk(1,0,0, 0,0,0, 1,0, 2'b00,2'b00, 0,1));
      vt.push_back(mk(1,0,0, 0,0,0, 0,0, 2'b00,2'b00, 0,1));
      vt.push_back(mk(1,0,0, 0,0,0, 0,0, 2'b00,2'b00, 0,1));
      // load to r0 never stalls
      vt.push_back(mk(1,0,0, 0,0,0, 1,1, 2'b00,2'b00, 0,1));
      vt.push_back(mk(1,0,0, 0,0,0, 0,0, 2'b00,2'b00, 0,1));
      vt.push_back(mk(1,0,0, 0,0,0, 0,0, 2'b00,2'b00, 0,1));
      vt.push_back(mk(1,0,0, 0,0,0, 0,0, 2'b00,2'b00, 0,1));
      // load-use under hold: stall persists until hold drops
      vt.push_back(mk(1,0,0, 0,0,10, 1,1, 2'b00,2'b00, 0,1));
      vt.push_back(mk(1,1,0, 10,0,13, 1,0, 2'b00,2'b00, 1,0));
      vt.push_back(mk(1,1,0, 10,0,13, 1,0, 2'b00,2'b00, 1,0));
      vt.push_back(mk(1,0,0, 10,0,13, 1,0, 2'b00,2'b00, 1,0));
      vt.push_back(mk(1,0,0, 10,0,13, 1,0, 2'b00,2'b00, 0,1));
      vt.push_back(mk(1,0,0, 0,0,0, 0,0, 2'b01,2'b00, 0,1));
      vt.push_back(mk(1,0,0, 0,0,0, 0,0, 2'b00,2'b00, 0,1));
      vt.push_back(mk(1,0,0, 0,0,0, 0,0, 2'b00,2'b00, 0,1));
      // reset mid-stream flushes all shadows
      vt.push_back(mk(1,0,0, 0,0,8, 1,0, 2'b00,2'b00, 0,1));
      vt.push_back(mk(1,0,0, 8,8,9, 1,1, 2'b00,2'b00, 0,1));
      vt.push_back(mk(0,0,0, 9,0,0, 0,0, 2'b10,2'b10, 1,0));
      vt.push_back(mk(1,0,0, 9,8,0, 0,0, 2'b00,2'b00, 0,1));
      vt.push_back(mk(1,0,0, 0,0,0, 0,0, 2'b00,2'b00, 0,1));
      vt.push_back(mk(1,0,0, 0,0,0, 0,0, 2'b00,2'b00, 0,1));

      // power-up reset edge before any check
      rst_i = 1'b0; hold_i = 1'b0; flush_i = 1'b0;
      id_rs_i = 5'd3; id_rt_i = 5'd4; id_rd_i = 5'd6;
      id_regwrite_i = 1'b1; id_memread_i = 1'b1;
      @(posedge clk_i);

      for (int i = 0; i < vt.size(); i++) begin
         step($sformatf("vec%0d", i), vt[i]);
      end

      // hold while forwarding is active: selects frozen, then resume as unheld
      step("hold_rd8",  mk(1,0,0, 0,0,8, 1,0, 2'b00,2'b00, 0,1));
      step("hold_rd9",  mk(1,0,0, 0,0,9, 1,0, 2'b00,2'b00, 0,1));
      step("hold_use",  mk(1,0,0, 8,9,0, 0,0, 2'b00,2'b00, 0,1));
      for (int k = 0; k < 3; k++) begin
         nop($sformatf("hold_frz%0d", k), 1'b1, 2'b01, 2'b10, 1'b0);
      end
      nop("hold_rel",  1'b0, 2'b01, 2'b10, 1'b1);
      nop("hold_next", 1'b0, 2'b00, 2'b00, 1'b1);

      // reset overrides hold
      step("rh_rd8", mk(1,0,0, 0,0,8, 1,0, 2'b00,2'b00, 0,1));
      step("rh_use", mk(1,0,0, 8,0,0, 0,0, 2'b00,2'b00, 0,1));
      step("rh_rst", mk(0,1,0, 0,0,0, 0,0, 2'b10,2'b00, 0,0));
      nop("rh_after", 1'b0, 2'b00, 2'b00, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Pipeline control block that generates the 2-bit operand-select codes consumed by the EX-stage 4:1 forwarding muxes, plus the load-use stall controls.
- Keeps its own shadow copies of the destination register, RegWrite and MemRead for the ID/EX, EX/MEM and MEM/WB stages.
- Sits beside the ID/EX pipeline register; the ID stage drives it and it drives the forwarding muxes, PC and IF/ID write enables.

Parameters:
- REG_W, 5, register-index width.
- SEL_W, 2, forward-select width; fixed to the mux encoding.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous active-low reset.
- hold_i  in  1  global freeze (memory stall); all shadow state holds.
- flush_i  in  1  ID instruction is killed (taken branch/jump).
- id_rs_i  in  REG_W  rs of the instruction in ID.
- id_rt_i  in  REG_W  rt of the instruction in ID.
- id_rd_i  in  REG_W  decoded destination (already rd/rt-selected).
- id_regwrite_i  in  1  ID instruction writes the register file.
- id_memread_i  in  1  ID instruction is a load.
- fwd_a_o  out  SEL_W  select for EX operand A.
- fwd_b_o  out  SEL_W  select for EX operand B.
- stall_o  out  1  load-use stall asserted this cycle.
- pc_write_o  out  1  PC write enable (= ~stall_o & ~hold_i).
- ifid_write_o  out  1  IF/ID write enable (= ~stall_o & ~hold_i).

Behaviour:
- Select encoding: 2'b00 = register-file value (ID/EX), 2'b01 = MEM/WB result, 2'b10 = EX/MEM ALU result; 2'b11 is never driven.
- State: ex_{rs,rt,rd,rw,mr}, mem_{rd,rw}, wb_{rd,rw}.
- Reset (rst_i=0 at an edge): all state clears to 0. The outputs follow from cleared state: fwd_a_o = fwd_b_o = 00, stall_o = 0, pc_write_o = ifid_write_o = 1.
- Per edge with rst_i=1 and hold_i=0:
  - Shift: wb <= mem, mem <= ex(rd, rw).
  - ex <= bubble (rs = rt = rd = 0, rw = mr = 0) if stall_o or flush_i; otherwise ex <= ID inputs.
- hold_i=1: every register keeps its value; pc_write_o and ifid_write_o = 0. Reset overrides hold_i.
- Forwarding (combinational from state only; valid in the cycle the instruction sits in EX, one cycle after it was presented in ID):
  - fwd_a_o = 10 if mem_rw & mem_rd != 0 & mem_rd == ex_rs.
  - Else fwd_a_o = 01 if wb_rw & wb_rd != 0 & wb_rd == ex_rs.
  - Else fwd_a_o = 00.
  - fwd_b_o uses the same rules with ex_rt.
  - EX/MEM has priority over MEM/WB when both match (the most recent producer wins).
  - Register 0 is never forwarded.
- Load-use stall: stall_o = ex_mr & ex_rd != 0 & (ex_rd == id_rs_i | ex_rd == id_rt_i) & ~flush_i.
  - It is combinational on ID inputs.
  - The stall lasts exactly one cycle per load-use pair, because the bubble clears ex_mr.
- flush_i and a stall condition in the same cycle: flush wins; stall_o = 0 and a bubble enters EX.
- hold_i and a stall condition together: stall_o may assert, but no state changes until hold_i drops.
- Reset mid-stream: the pipeline shadows empty in one edge; no stale forwarding after reset.

Test Plan:
- Reset: rst_i=0 for 2 cycles with random ID inputs -> fwd_a_o = fwd_b_o = 00, stall_o = 0, pc_write_o = 1.
- EX/MEM forward: add rd=8 (rw=1), then next instr rs=8, rt=9 -> in the second instr's EX cycle, fwd_a_o = 10, fwd_b_o = 00.
- MEM/WB forward and priority:
  - Sequence: instr rd=8, instr rd=9, instr rs=8, rt=9 -> fwd_a_o = 01, fwd_b_o = 10.
  - Sequence: instr rd=8, instr rd=8, instr rs=8 -> fwd_a_o = 10.
- Load-use: lw rd=10 (mr=1), then instr rt=10:
  - One cycle of stall_o = 1 with pc_write_o = ifid_write_o = 0, and a bubble in EX.
  - Next cycle stall_o = 0, and the dependent instr later gets fwd_b_o = 01.
- Flush/zero register: lw rd=10 followed by rs=10 with flush_i=1 -> stall_o = 0. Separately, writes to rd=0 with rw=1 -> fwd_a_o stays 00.
- Hold: assert hold_i for 3 cycles mid-sequence -> fwd_*_o unchanged, pc_write_o = 0. After release, the forwarding sequence resumes identically to an unheld run.
